// File: rtl/ifu_ir_queue_if.sv
// Handshake bundle between the IFU IR/PC stage, the instruction queue and EXU dispatch.
// The master modport is the environment side; the slave modport is the queue itself.
interface ifu_ir_queue_if #(
    parameter int DEPTH      = 2,
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  i_valid;
    logic                  i_ready;
    logic [INSTR_SIZE-1:0] i_ir;
    logic [PC_SIZE-1:0]    i_pc;
    logic                  i_misalgn;
    logic                  i_buserr;
    logic                  i_prdt_taken;

    logic                  o_valid;
    logic                  o_ready;
    logic [INSTR_SIZE-1:0] o_ir;
    logic [PC_SIZE-1:0]    o_pc;
    logic                  o_misalgn;
    logic                  o_buserr;
    logic                  o_prdt_taken;
    logic [4:0]            o_rs1idx;
    logic [4:0]            o_rs2idx;

    logic                  flush;
    logic [CNT_W-1:0]      count;

    modport master (
        output i_valid, i_ir, i_pc, i_misalgn, i_buserr, i_prdt_taken, o_ready, flush,
        input  i_ready, o_valid, o_ir, o_pc, o_misalgn, o_buserr, o_prdt_taken,
               o_rs1idx, o_rs2idx, count
    );

    modport slave (
        input  i_valid, i_ir, i_pc, i_misalgn, i_buserr, i_prdt_taken, o_ready, flush,
        output i_ready, o_valid, o_ir, o_pc, o_misalgn, o_buserr, o_prdt_taken,
               o_rs1idx, o_rs2idx, count
    );
endinterface

// File: rtl/ifu_ir_queue.sv
// IFU -> EXU instruction queue: circular buffer with side-band flags and one-cycle flush.
// Define IFU_IRQ_BYPASS_EN for a zero-latency pass-through path while the queue is empty.
module ifu_ir_queue #(
    parameter int DEPTH      = 2,
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32
) (
    input  logic           clk,
    input  logic           rst,
    ifu_ir_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [INSTR_SIZE-1:0] ir;
        logic [PC_SIZE-1:0]    pc;
        logic                  misalgn;
        logic                  buserr;
        logic                  prdt_taken;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;

    entry_t in_entry;
    entry_t head;
    logic   empty;
    logic   in_ready;
    logic   out_valid;
    logic   push;
    logic   pop;
    logic   wr_en;
    logic   rd_en;

    assign in_entry = '{ir: bus.i_ir, pc: bus.i_pc, misalgn: bus.i_misalgn,
                        buserr: bus.i_buserr, prdt_taken: bus.i_prdt_taken};
    assign empty    = (cnt == '0);

    // Acceptance looks only at occupancy, so the fetch path never waits on EXU timing.
    assign in_ready = (cnt != FULL) & ~bus.flush;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        head      = mem[rptr];
        out_valid = ~empty & ~bus.flush;
`ifdef IFU_IRQ_BYPASS_EN
        if (empty & ~bus.flush) begin
            head      = in_entry;
            out_valid = bus.i_valid;
        end
`endif
    end

    assign push = bus.i_valid & in_ready;
    assign pop  = out_valid & bus.o_ready;

    // An empty-queue pop can only be the bypassed entry; it is neither stored nor dequeued.
    assign wr_en = push & ~(empty & pop);
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset as well, because an empty queue presents entry[0] as zero.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= in_entry;
                wptr      <= wptr + PTR_W'(1);
            end
            if (rd_en) begin
                rptr <= rptr + PTR_W'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.i_ready      = in_ready;
    assign bus.o_valid      = out_valid;
    assign bus.o_ir         = head.ir;
    assign bus.o_pc         = head.pc;
    assign bus.o_misalgn    = head.misalgn;
    assign bus.o_buserr     = head.buserr;
    assign bus.o_prdt_taken = head.prdt_taken;
    assign bus.o_rs1idx     = head.ir[19:15];
    assign bus.o_rs2idx     = head.ir[24:20];
    assign bus.count        = cnt;
endmodule

// File: tb/tb_ifu_ir_queue.sv
// Bench for ifu_ir_queue: directed vector table, async-reset sequence, random run vs a queue model.
// Honours IFU_IRQ_BYPASS_EN when the design is built with it.
module tb_ifu_ir_queue;
    localparam int DEPTH      = 2;
    localparam int PC_SIZE    = 32;
    localparam int INSTR_SIZE = 32;

    logic clk = 1'b0;
    logic rst;

    ifu_ir_queue_if #(.DEPTH(DEPTH), .PC_SIZE(PC_SIZE), .INSTR_SIZE(INSTR_SIZE)) bus ();

    ifu_ir_queue #(.DEPTH(DEPTH), .PC_SIZE(PC_SIZE), .INSTR_SIZE(INSTR_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ord, input logic fl,
                         input logic [31:0] pc, input logic [31:0] ir, input logic [2:0] flg);
        bus.i_valid      = iv;
        bus.o_ready      = ord;
        bus.flush        = fl;
        bus.i_pc         = pc;
        bus.i_ir         = ir;
        bus.i_misalgn    = flg[2];
        bus.i_buserr     = flg[1];
        bus.i_prdt_taken = flg[0];
    endtask

    function automatic logic [2:0] out_flags();
        return {bus.o_misalgn, bus.o_buserr, bus.o_prdt_taken};
    endfunction

    typedef struct {
        logic        iv, ord, fl;
        logic [31:0] pc, ir;
        logic [2:0]  flg;
        logic        eov, eird;
        logic [1:0]  ecnt;
        logic [31:0] epc, eir;
        logic [2:0]  eflg;
    } vec_t;

    function automatic vec_t mk(logic iv, logic ord, logic fl, logic [31:0] pc, logic [31:0] ir,
                                logic [2:0] flg, logic eov, logic eird, logic [1:0] ecnt,
                                logic [31:0] epc, logic [31:0] eir, logic [2:0] eflg);
        vec_t v;
        v = '{iv, ord, fl, pc, ir, flg, eov, eird, ecnt, epc, eir, eflg};
        return v;
    endfunction

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [2:0]  flg;
    } ent_t;

    vec_t vecs[$];
    ent_t model[$];

    initial begin
        ent_t        stim;
        ent_t        hd;
        logic        iv, ord, fl, exp_ov, exp_ird, push, pop;
        int          n;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check("reset o_valid", bus.o_valid, 0);
        check("reset i_ready", bus.i_ready, 1);
        check("reset count", bus.count, 0);
        check("reset o_ir", bus.o_ir, 0);
        check("reset o_pc", bus.o_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifndef IFU_IRQ_BYPASS_EN
        //            iv ord fl pc            ir            flg  eov eird cnt epc           eir           eflg
        vecs.push_back(mk(1, 1, 0, 32'h80000000, 32'h00A00093, 0, 0, 1, 0, 0,            0,            0));
        vecs.push_back(mk(0, 1, 0, 0,            0,            0, 1, 1, 1, 32'h80000000, 32'h00A00093, 0));
        vecs.push_back(mk(0, 1, 0, 0,            0,            0, 0, 1, 0, 0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 32'h100,      32'hA0000100, 0, 0, 1, 0, 0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 32'h104,      32'hA0000104, 0, 1, 1, 1, 32'h100,      32'hA0000100, 0));
        vecs.push_back(mk(1, 0, 0, 32'h108,      32'hA0000108, 0, 1, 0, 2, 32'h100,      32'hA0000100, 0));
        vecs.push_back(mk(1, 1, 0, 32'h108,      32'hA0000108, 0, 1, 0, 2, 32'h100,      32'hA0000100, 0));
        vecs.push_back(mk(1, 1, 0, 32'h108,      32'hA0000108, 0, 1, 1, 1, 32'h104,      32'hA0000104, 0));
        vecs.push_back(mk(0, 1, 0, 0,            0,            0, 1, 1, 1, 32'h108,      32'hA0000108, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0,            0, 0, 1, 0, 0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 32'h300,      32'hA0000300, 0, 0, 1, 0, 0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 32'h304,      32'hA0000304, 0, 1, 1, 1, 32'h300,      32'hA0000300, 0));
        vecs.push_back(mk(1, 1, 1, 32'h308,      32'hA0000308, 0, 0, 0, 2, 0,            0,            0));
        vecs.push_back(mk(1, 1, 1, 32'h308,      32'hA0000308, 0, 0, 0, 0, 0,            0,            0));
        vecs.push_back(mk(0, 1, 0, 0,            0,            0, 0, 1, 0, 0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 32'h1FC,      32'hA00001FC, 0, 0, 1, 0, 0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 32'h200,      32'hA0000200, 7, 1, 1, 1, 32'h1FC,      32'hA00001FC, 0));
        vecs.push_back(mk(1, 1, 0, 32'h204,      32'hA0000204, 0, 1, 0, 2, 32'h1FC,      32'hA00001FC, 0));
        vecs.push_back(mk(1, 1, 0, 32'h204,      32'hA0000204, 0, 1, 1, 1, 32'h200,      32'hA0000200, 7));
        vecs.push_back(mk(0, 1, 0, 0,            0,            0, 1, 1, 1, 32'h204,      32'hA0000204, 0));
        vecs.push_back(mk(0, 1, 0, 0,            0,            0, 0, 1, 0, 0,            0,            0));

        foreach (vecs[k]) begin
            drive(vecs[k].iv, vecs[k].ord, vecs[k].fl, vecs[k].pc, vecs[k].ir, vecs[k].flg);
            @(negedge clk);
            check($sformatf("vec%0d o_valid", k), bus.o_valid, vecs[k].eov);
            check($sformatf("vec%0d i_ready", k), bus.i_ready, vecs[k].eird);
            check($sformatf("vec%0d count", k), bus.count, vecs[k].ecnt);
            if (vecs[k].eov) begin
                check($sformatf("vec%0d o_pc", k), bus.o_pc, vecs[k].epc);
                check($sformatf("vec%0d o_ir", k), bus.o_ir, vecs[k].eir);
                check($sformatf("vec%0d flags", k), out_flags(), vecs[k].eflg);
                check($sformatf("vec%0d rs1", k), bus.o_rs1idx, vecs[k].eir[19:15]);
                check($sformatf("vec%0d rs2", k), bus.o_rs2idx, vecs[k].eir[24:20]);
            end
            @(posedge clk);
            #1;
        end
`else
        drive(1, 1, 0, 32'h80000000, 32'h00A00093, 0);
        #1;
        check("bypass o_valid", bus.o_valid, 1);
        check("bypass o_ir", bus.o_ir, 32'h00A00093);
        check("bypass o_pc", bus.o_pc, 32'h80000000);
        check("bypass count", bus.count, 0);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 0, 0, 0);
        check("bypass count after", bus.count, 0);
        check("bypass empty o_valid", bus.o_valid, 0);
        @(posedge clk);
        #1;
`endif

        // Asynchronous reset with two entries held.
        drive(1, 0, 0, 32'h400, 32'hA0000400, 0);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 32'h404, 32'hA0000404, 0);
        @(posedge clk);
        #1;
        check("pre-rst count", bus.count, 2);
        check("pre-rst o_valid", bus.o_valid, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst o_valid", bus.o_valid, 0);
        check("async rst count", bus.count, 0);
        check("async rst i_ready", bus.i_ready, 1);
        @(posedge clk);
        #1;
        check("held rst count", bus.count, 0);
        check("held rst i_ready", bus.i_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic against a plain FIFO model.
        model.delete();
        for (int c = 0; c < 400; c++) begin
            stim.ir  = $urandom;
            stim.pc  = $urandom;
            stim.flg = 3'($urandom);
            iv  = ($urandom_range(0, 3) != 0);
            ord = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            drive(iv, ord, fl, stim.pc, stim.ir, stim.flg);
            @(negedge clk);
            n       = model.size();
            exp_ird = (n != DEPTH) && !fl;
            exp_ov  = (n != 0) && !fl;
            if (n != 0) hd = model[0];
`ifdef IFU_IRQ_BYPASS_EN
            if (n == 0 && !fl) begin
                exp_ov = iv;
                hd     = stim;
            end
`endif
            check($sformatf("rnd%0d count", c), bus.count, 64'(n));
            check($sformatf("rnd%0d i_ready", c), bus.i_ready, exp_ird);
            check($sformatf("rnd%0d o_valid", c), bus.o_valid, exp_ov);
            if (exp_ov) begin
                check($sformatf("rnd%0d o_pc", c), bus.o_pc, hd.pc);
                check($sformatf("rnd%0d o_ir", c), bus.o_ir, hd.ir);
                check($sformatf("rnd%0d flags", c), out_flags(), hd.flg);
                check($sformatf("rnd%0d rs1", c), bus.o_rs1idx, hd.ir[19:15]);
                check($sformatf("rnd%0d rs2", c), bus.o_rs2idx, hd.ir[24:20]);
            end
            push = iv && exp_ird;
            pop  = exp_ov && ord;
            @(posedge clk);
            #1;
            if (fl) begin
                model.delete();
            end else if (!(pop && n == 0)) begin
                if (pop)  void'(model.pop_front());
                if (push) model.push_back(stim);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
